// File: rtl/vxu_bank_slice_if.sv
// Command-chain, writeback-bus and read-port bundle of one vector-lane bank slice.
// The slice itself connects through the slave modport; the upstream driver uses master.
interface vxu_bank_slice_if #(
    parameter int DATA_W = 65,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 3,
    parameter int NWBUS  = 4,
    parameter int SEL_W  = 2
);
    // Bank control
    logic                    active;
    logic                    stall;

    // Incoming read command
    logic                    in_ren;
    logic                    in_rlast;
    logic [CNT_W-1:0]        in_rcnt;
    logic [ADDR_W-1:0]       in_raddr;

    // Incoming write command
    logic                    in_wen;
    logic                    in_wlast;
    logic [CNT_W-1:0]        in_wcnt;
    logic [ADDR_W-1:0]       in_waddr;
    logic [SEL_W-1:0]        in_wsel;

    // Forwarded read command
    logic                    out_ren;
    logic                    out_rlast;
    logic [CNT_W-1:0]        out_rcnt;
    logic [ADDR_W-1:0]       out_raddr;

    // Forwarded write command
    logic                    out_wen;
    logic                    out_wlast;
    logic [CNT_W-1:0]        out_wcnt;
    logic [ADDR_W-1:0]       out_waddr;
    logic [SEL_W-1:0]        out_wsel;

    // Writeback buses, bus i at [i*DATA_W +: DATA_W]
    logic [NWBUS*DATA_W-1:0] wbus;

    // Read port
    logic [DATA_W-1:0]       rdata;
    logic                    rdata_val;
    logic                    rdone;

    modport slave (
        input  active, stall,
        input  in_ren, in_rlast, in_rcnt, in_raddr,
        input  in_wen, in_wlast, in_wcnt, in_waddr, in_wsel,
        output out_ren, out_rlast, out_rcnt, out_raddr,
        output out_wen, out_wlast, out_wcnt, out_waddr, out_wsel,
        input  wbus,
        output rdata, rdata_val, rdone
    );

    modport master (
        output active, stall,
        output in_ren, in_rlast, in_rcnt, in_raddr,
        output in_wen, in_wlast, in_wcnt, in_waddr, in_wsel,
        input  out_ren, out_rlast, out_rcnt, out_raddr,
        input  out_wen, out_wlast, out_wcnt, out_waddr, out_wsel,
        output wbus,
        input  rdata, rdata_val, rdone
    );
endinterface

// File: rtl/vxu_bank_slice.sv
// vxu_bank_slice: one bank of the vector-lane register file together with the
// command-chain stage that forwards read/write sequencing commands to the next bank.
// An inactive bank is a pure combinational bypass of the chain; a stall freezes
// every register of the slice (chain, read pipeline and regfile writes).
module vxu_bank_slice #(
    parameter int DATA_W = 65,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 3,
    parameter int NWBUS  = 4,
    parameter int SEL_W  = 2,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    vxu_bank_slice_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [SEL_W-1:0]  SEL_ZERO  = {SEL_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Pick writeback bus 'sel'; out-of-range selects return zero (and are never written).
    function automatic logic [DATA_W-1:0] sel_bus(
        input logic [NWBUS*DATA_W-1:0] buses,
        input logic [SEL_W-1:0]        sel
    );
        logic [DATA_W-1:0] res;
        res = DATA_ZERO;
        for (int i = 0; i < NWBUS; i++) begin
            if (int'(sel) == i) begin
                res = buses[i*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    // True when 'sel' names an existing writeback bus.
    function automatic logic wsel_in_range(input logic [SEL_W-1:0] sel);
        return (int'(sel) < NWBUS);
    endfunction

    // Decrement a chain count, saturating at zero so a spent command never wraps.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
        return (cnt != CNT_ZERO) ? (cnt - CNT_ONE) : CNT_ZERO;
    endfunction

    // ------------------------------------------------------------------
    // Command chain registers
    // ------------------------------------------------------------------
    logic              r_ren;
    logic              r_rlast;
    logic [CNT_W-1:0]  r_rcnt;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_wen;
    logic              r_wlast;
    logic [CNT_W-1:0]  r_wcnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [SEL_W-1:0]  r_wsel;

    logic              w_rpass;
    logic              w_wpass;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic [DATA_W-1:0] w_wr_data;

    // A command is forwarded only while banks remain downstream of this one.
    assign w_rpass    = |bus.in_rcnt;
    assign w_wpass    = |bus.in_wcnt;

    // Local regfile accesses happen only in a participating, unfrozen bank.
    assign w_rd_issue = bus.in_ren & bus.active & ~bus.stall;
    assign w_wr_issue = bus.in_wen & bus.active & ~bus.stall & wsel_in_range(bus.in_wsel);
    assign w_wr_data  = sel_bus(bus.wbus, bus.in_wsel);

    // Chain stage: capture incoming commands and hand them to the next bank one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ren   <= 1'b0;
            r_rlast <= 1'b0;
            r_rcnt  <= CNT_ZERO;
            r_raddr <= ADDR_ZERO;
            r_wen   <= 1'b0;
            r_wlast <= 1'b0;
            r_wcnt  <= CNT_ZERO;
            r_waddr <= ADDR_ZERO;
            r_wsel  <= SEL_ZERO;
        end else if (!bus.stall) begin
            r_ren   <= bus.in_ren & w_rpass;
            r_rlast <= bus.in_rlast;
            r_rcnt  <= cnt_next(bus.in_rcnt);
            r_raddr <= bus.in_raddr;
            r_wen   <= bus.in_wen & w_wpass;
            r_wlast <= bus.in_wlast;
            r_wcnt  <= cnt_next(bus.in_wcnt);
            r_waddr <= bus.in_waddr;
            r_wsel  <= bus.in_wsel;
        end else begin
            r_ren   <= r_ren;
            r_rlast <= r_rlast;
            r_rcnt  <= r_rcnt;
            r_raddr <= r_raddr;
            r_wen   <= r_wen;
            r_wlast <= r_wlast;
            r_wcnt  <= r_wcnt;
            r_waddr <= r_waddr;
            r_wsel  <= r_wsel;
        end
    end

    // Inactive banks add no latency: the chain passes straight through.
    assign bus.out_ren   = bus.active ? r_ren   : bus.in_ren;
    assign bus.out_rlast = bus.active ? r_rlast : bus.in_rlast;
    assign bus.out_rcnt  = bus.active ? r_rcnt  : bus.in_rcnt;
    assign bus.out_raddr = bus.active ? r_raddr : bus.in_raddr;
    assign bus.out_wen   = bus.active ? r_wen   : bus.in_wen;
    assign bus.out_wlast = bus.active ? r_wlast : bus.in_wlast;
    assign bus.out_wcnt  = bus.active ? r_wcnt  : bus.in_wcnt;
    assign bus.out_waddr = bus.active ? r_waddr : bus.in_waddr;
    assign bus.out_wsel  = bus.active ? r_wsel  : bus.in_wsel;

    // ------------------------------------------------------------------
    // Register file (contents deliberately survive reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Regfile write port; the read below samples the pre-write word (read-before-write).
    always_ff @(posedge clk) begin
        if (w_wr_issue) begin
            r_mem[bus.in_waddr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline, first stage
    // ------------------------------------------------------------------
    logic              r_rd1_val;
    logic              r_rd1_last;
    logic [DATA_W-1:0] r_rd1_data;

    // Stage 1: capture the addressed word; data/last hold when no new read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd1_val  <= 1'b0;
            r_rd1_last <= 1'b0;
            r_rd1_data <= DATA_ZERO;
        end else if (!bus.stall) begin
            r_rd1_val <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd1_last <= bus.in_rlast;
                r_rd1_data <= r_mem[bus.in_raddr];
            end else begin
                r_rd1_last <= r_rd1_last;
                r_rd1_data <= r_rd1_data;
            end
        end else begin
            r_rd1_val  <= r_rd1_val;
            r_rd1_last <= r_rd1_last;
            r_rd1_data <= r_rd1_data;
        end
    end

    logic              w_rd_val;
    logic              w_rd_last;
    logic [DATA_W-1:0] w_rd_data;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_rd2_val;
            logic              r_rd2_last;
            logic [DATA_W-1:0] r_rd2_data;

            // Stage 2: extra register stage; output data holds until the next valid entry.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd2_val  <= 1'b0;
                    r_rd2_last <= 1'b0;
                    r_rd2_data <= DATA_ZERO;
                end else if (!bus.stall) begin
                    r_rd2_val <= r_rd1_val;
                    if (r_rd1_val) begin
                        r_rd2_last <= r_rd1_last;
                        r_rd2_data <= r_rd1_data;
                    end else begin
                        r_rd2_last <= r_rd2_last;
                        r_rd2_data <= r_rd2_data;
                    end
                end else begin
                    r_rd2_val  <= r_rd2_val;
                    r_rd2_last <= r_rd2_last;
                    r_rd2_data <= r_rd2_data;
                end
            end

            assign w_rd_val  = r_rd2_val;
            assign w_rd_last = r_rd2_last;
            assign w_rd_data = r_rd2_data;
        end else begin : g_lat1
            assign w_rd_val  = r_rd1_val;
            assign w_rd_last = r_rd1_last;
            assign w_rd_data = r_rd1_data;
        end
    endgenerate

    // A frozen pipeline presents nothing; the held entry reappears once stall drops.
    assign bus.rdata     = w_rd_data;
    assign bus.rdata_val = w_rd_val & ~bus.stall;
    assign bus.rdone     = w_rd_val & ~bus.stall & w_rd_last;

endmodule

// File: tb/tb_vxu_bank_slice.sv
// Scoreboard bench for vxu_bank_slice: the driver pushes expected read responses
// (from a plain array model of the regfile) and a negedge monitor pops and compares.
module tb_vxu_bank_slice;
    localparam int DATA_W = 65;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 3;
    localparam int NWBUS  = 4;
    localparam int SEL_W  = 3;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int OW     = 2 * (1 + 1 + CNT_W + ADDR_W) + SEL_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vxu_bank_slice_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                        .NWBUS(NWBUS), .SEL_W(SEL_W)) bus ();

    vxu_bank_slice #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                     .NWBUS(NWBUS), .SEL_W(SEL_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference regfile and pending read responses
    logic [DATA_W-1:0] mdl [DEPTH];
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        longint            due;
    } rd_t;
    rd_t sbq[$];

    // Number of unstalled, non-reset clock edges seen so far
    longint ucnt = 0;

    // Expected chain-stage contents (what an active bank forwards)
    logic              e_ren = 1'b0, e_rlast = 1'b0, e_wen = 1'b0, e_wlast = 1'b0;
    logic [CNT_W-1:0]  e_rcnt = '0, e_wcnt = '0;
    logic [ADDR_W-1:0] e_raddr = '0, e_waddr = '0;
    logic [SEL_W-1:0]  e_wsel = '0;

    // Chain model: a command moves on only while banks remain, count drops by one.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_ren <= 1'b0; e_rlast <= 1'b0; e_rcnt <= '0; e_raddr <= '0;
            e_wen <= 1'b0; e_wlast <= 1'b0; e_wcnt <= '0; e_waddr <= '0; e_wsel <= '0;
        end else if (!bus.stall) begin
            e_ren   <= bus.in_ren && (bus.in_rcnt != 0);
            e_rcnt  <= (bus.in_rcnt == 0) ? 3'd0 : bus.in_rcnt - 3'd1;
            e_rlast <= bus.in_rlast;
            e_raddr <= bus.in_raddr;
            e_wen   <= bus.in_wen && (bus.in_wcnt != 0);
            e_wcnt  <= (bus.in_wcnt == 0) ? 3'd0 : bus.in_wcnt - 3'd1;
            e_wlast <= bus.in_wlast;
            e_waddr <= bus.in_waddr;
            e_wsel  <= bus.in_wsel;
            ucnt    <= ucnt + 1;
        end
    end

    // Monitor: compare forwarded commands and the read port each negedge.
    always @(negedge clk) begin
        logic [OW-1:0] exp_o, act_o;
        act_o = {bus.out_ren, bus.out_rlast, bus.out_rcnt, bus.out_raddr,
                 bus.out_wen, bus.out_wlast, bus.out_wcnt, bus.out_waddr, bus.out_wsel};
        if (bus.active)
            exp_o = {e_ren, e_rlast, e_rcnt, e_raddr, e_wen, e_wlast, e_wcnt, e_waddr, e_wsel};
        else
            exp_o = {bus.in_ren, bus.in_rlast, bus.in_rcnt, bus.in_raddr,
                     bus.in_wen, bus.in_wlast, bus.in_wcnt, bus.in_waddr, bus.in_wsel};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL chain t=%0t got=%h expected=%h", $time, act_o, exp_o);
        end

        if (sbq.size() != 0 && sbq[0].due < ucnt) begin
            checks++;
            errors++;
            $display("FAIL rd_missed t=%0t data=%h never presented", $time, sbq[0].data);
            void'(sbq.pop_front());
        end

        if (!reset && !bus.stall && sbq.size() != 0 && sbq[0].due == ucnt) begin
            checks++;
            if (bus.rdata_val !== 1'b1 || bus.rdata !== sbq[0].data || bus.rdone !== sbq[0].last) begin
                errors++;
                $display("FAIL rd_resp t=%0t got val=%b data=%h done=%b expected val=1 data=%h done=%b",
                         $time, bus.rdata_val, bus.rdata, bus.rdone, sbq[0].data, sbq[0].last);
            end
            void'(sbq.pop_front());
        end else begin
            checks++;
            if (bus.rdata_val !== 1'b0 || bus.rdone !== 1'b0) begin
                errors++;
                $display("FAIL rd_idle t=%0t got val=%b done=%b expected 0/0",
                         $time, bus.rdata_val, bus.rdone);
            end
        end
    end

    function automatic logic [DATA_W-1:0] rnd_word();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.active   = 1'b1; bus.stall    = 1'b0;
        bus.in_ren   = 1'b0; bus.in_rlast = 1'b0; bus.in_rcnt = '0; bus.in_raddr = '0;
        bus.in_wen   = 1'b0; bus.in_wlast = 1'b0; bus.in_wcnt = '0; bus.in_waddr = '0;
        bus.in_wsel  = '0;
    endtask

    task automatic rnd_buses();
        for (int i = 0; i < NWBUS; i++) bus.wbus[i*DATA_W +: DATA_W] = rnd_word();
    endtask

    // Record the effect of the inputs just driven: queue the read, then apply the write.
    task automatic commit();
        if (!reset && bus.active && !bus.stall) begin
            if (bus.in_ren)
                sbq.push_back('{data: mdl[bus.in_raddr], last: bus.in_rlast, due: ucnt + RD_LAT});
            if (bus.in_wen && int'(bus.in_wsel) < NWBUS)
                mdl[bus.in_waddr] = bus.wbus[int'(bus.in_wsel)*DATA_W +: DATA_W];
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic last);
        tick(); set_idle();
        bus.in_ren = 1'b1; bus.in_raddr = a; bus.in_rlast = last; bus.in_rcnt = 3'd2;
        commit();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [SEL_W-1:0] s,
                            input logic [DATA_W-1:0] d);
        tick(); set_idle(); rnd_buses();
        if (int'(s) < NWBUS) bus.wbus[int'(s)*DATA_W +: DATA_W] = d;
        bus.in_wen = 1'b1; bus.in_waddr = a; bus.in_wsel = s; bus.in_wcnt = 3'd1;
        commit();
    endtask

    task automatic rnd_cycle(input int stall_pct);
        tick(); rnd_buses();
        bus.active   = ($urandom_range(0, 7) != 0);
        bus.stall    = ($urandom_range(0, 99) < stall_pct);
        bus.in_ren   = 1'($urandom);  bus.in_rlast = 1'($urandom);
        bus.in_rcnt  = 3'($urandom);  bus.in_raddr = 8'($urandom);
        bus.in_wen   = 1'($urandom);  bus.in_wlast = 1'($urandom);
        bus.in_wcnt  = 3'($urandom);  bus.in_waddr = 8'($urandom);
        bus.in_wsel  = 3'($urandom);
        commit();
    endtask

    initial begin
        set_idle();
        bus.wbus = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Fill the whole regfile so every later read has a known value
        for (int a = 0; a < DEPTH; a++) do_write(8'(a), 3'($urandom_range(0, NWBUS - 1)), rnd_word());

        // Basic write bus 2 then read back
        do_write(8'd5, 3'd2, 65'h1_2345);
        do_read(8'd5, 1'b0);

        // Same-cycle read and write to one address: old data first, new data next
        do_write(8'd7, 3'd1, 65'hAA);
        tick(); set_idle(); rnd_buses();
        bus.wbus[3*DATA_W +: DATA_W] = 65'hBB;
        bus.in_ren = 1'b1; bus.in_raddr = 8'd7;
        bus.in_wen = 1'b1; bus.in_waddr = 8'd7; bus.in_wsel = 3'd3;
        commit();
        do_read(8'd7, 1'b0);

        // Out-of-range bus select leaves the entry alone
        do_write(8'd7, 3'd5, rnd_word());
        do_read(8'd7, 1'b0);

        // Four back-to-back reads, last flagged on the fourth
        for (int i = 0; i < 4; i++) do_read(8'(10 + i), (i == 3));

        // Chain forwarding: count 3, count 0, then an inactive bank
        tick(); set_idle(); bus.in_ren = 1'b1; bus.in_rcnt = 3'd3; bus.in_raddr = 8'd9; commit();
        tick(); set_idle(); bus.in_ren = 1'b1; bus.in_rcnt = 3'd0; bus.in_wen = 1'b1; bus.in_wcnt = 3'd0; commit();
        tick(); set_idle(); bus.active = 1'b0; bus.in_ren = 1'b1; bus.in_rcnt = 3'd4;
        bus.in_wen = 1'b1; bus.in_wcnt = 3'd2; bus.in_wsel = 3'd1; commit();

        // Read followed by a three-cycle stall carrying writes that must not land
        do_read(8'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); rnd_buses(); bus.stall = 1'b1;
            bus.in_ren = 1'b1; bus.in_raddr = 8'd5; bus.in_rcnt = 3'd2;
            bus.in_wen = 1'b1; bus.in_waddr = 8'd5; bus.in_wsel = 3'd0; bus.in_wcnt = 3'd3;
            commit();
        end
        tick(); set_idle(); commit();
        do_read(8'd5, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) rnd_cycle(20);

        // Reset between edges while a read is being presented
        tick(); set_idle(); bus.in_ren = 1'b1; bus.in_rcnt = 3'd3; bus.in_raddr = 8'd5; commit();
        tick(); set_idle(); bus.in_ren = 1'b1; bus.in_rcnt = 3'd3; bus.in_raddr = 8'd7; commit();
        #2;
        reset = 1'b1;
        sbq.delete();
        #1;
        checks++;
        if (bus.out_ren !== 1'b0 || bus.rdata_val !== 1'b0 || bus.rdone !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got out_ren=%b val=%b done=%b expected 0/0/0",
                     bus.out_ren, bus.rdata_val, bus.rdone);
        end
        tick();
        tick(); set_idle(); reset = 1'b0; commit();
        do_read(8'd5, 1'b0);
        do_read(8'd7, 1'b1);

        for (int i = 0; i < 800; i++) rnd_cycle(20);

        // Drain and confirm every queued response was delivered
        for (int i = 0; i < RD_LAT + 4; i++) begin
            tick(); set_idle(); commit();
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending responses expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vxu_bank_slice.md
Name: vxu_bank_slice

Overview:
- Parametrised next-generation vector-lane bank slice: per-bank SRAM register file plus the read/write command-chain stage that forwards sequencing commands bank-to-bank.
- Generalised in data width, regfile depth, write-bus count, chain counter width and read latency.
- Adds a global stall (pipeline freeze), a read-data valid and a last-element completion pulse.
- Instantiated once per bank; slices are daisy-chained through the out_*/in_* command ports.

Parameters:
DATA_W, 65, regfile word width
ADDR_W, 8, regfile address width (depth 2**ADDR_W entries)
CNT_W, 3, chain count width (log2 of bank count)
NWBUS, 4, number of writeback buses
SEL_W, 2, width of write-bus select (>= clog2(NWBUS))
RD_LAT, 1, regfile read latency in cycles (legal values 1 or 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
active  in  1  this bank participates; 0 = pure combinational bypass
stall  in  1  freeze all state in this slice
in_ren, in_rlast  in  1 each  read command valid / last element
in_rcnt  in  CNT_W  remaining banks for read command
in_raddr  in  ADDR_W  read address
in_wen, in_wlast  in  1 each  write command valid / last element
in_wcnt  in  CNT_W  remaining banks for write command
in_waddr  in  ADDR_W  write address
in_wsel  in  SEL_W  writeback bus select
out_ren, out_rlast, out_rcnt, out_raddr  out  as inputs  forwarded read command
out_wen, out_wlast, out_wcnt, out_waddr, out_wsel  out  as inputs  forwarded write command
wbus  in  NWBUS*DATA_W  packed writeback buses, bus i at bits [i*DATA_W +: DATA_W]
rdata  out  DATA_W  regfile read data
rdata_val  out  1  rdata valid
rdone  out  1  pulse: valid read carrying rlast delivered

Behaviour:
- rpass = |in_rcnt; wpass = |in_wcnt.
- Chain stage, per clk edge when stall=0:
  - reg_ren <= in_ren & rpass.
  - reg_rcnt <= rpass ? in_rcnt-1 : 0.
  - reg_rlast, reg_raddr <= inputs.
  - Write side identical: reg_wen <= in_wen & wpass; reg_wcnt decrements the same way; reg_wlast, reg_waddr, reg_wsel <= inputs.
- stall=1: every register holds, including the read pipeline.
- out_* = active ? reg_* : in_* (combinational bypass). Chain latency: 1 cycle per active bank, 0 per inactive bank.
- Count of zero never underflows: rcnt/wcnt stay 0 and the forwarded en is 0.
- Read:
  - Issued when in_ren & active & ~stall.
  - Data from in_raddr appears on rdata exactly RD_LAT unstalled cycles later, with rdata_val=1 for one cycle.
  - rdone = rdata_val & (captured in_rlast).
  - RD_LAT=2 adds one register stage on data, valid and last.
  - rdata holds its last value when not valid.
- Stall on the read output: rdata_val and rdone are gated low while stall=1 and reassert after release if the pipeline still holds a valid entry.
- Write:
  - Issued when in_wen & active & ~stall.
  - Writes bus in_wsel into entry in_waddr at that edge.
  - in_wsel >= NWBUS: write suppressed, no other effect.
- Simultaneous read and write to the same address in the same cycle: read returns the old data (read-before-write).
- Back-to-back reads and writes every cycle are sustained; no bubbles.
- Reset (asynchronous, takes effect immediately, including mid-command):
  - reg_ren, reg_wen, reg_rlast, reg_wlast, all read-pipeline valids = 0.
  - Counts, addresses and wsel = 0; rdata = 0.
  - Regfile contents are not reset.
  - During and after reset, rdata_val=0 and rdone=0.
  - out_* reflect reg_* (zeros) if active, else the inputs.

Test Plan:
- Defaults, active=1: write wbus[2]=0x1_2345 to addr 5 (wsel=2), then read addr 5 -> rdata=0x1_2345, rdata_val=1 exactly 1 cycle after issue; RD_LAT=2 build -> 2 cycles.
- Chain: in_ren=1, in_rcnt=3 -> next cycle out_ren=1, out_rcnt=2. in_rcnt=0 -> out_ren=0, out_rcnt=0. active=0 -> out_* equal in_* the same cycle.
- Stall: issue read, assert stall for 3 cycles -> rdata_val=0 throughout and no regfile write occurs; release -> rdata_val=1 with correct data; out_* unchanged during stall.
- Same-cycle read and write to addr 7 (old 0xAA, new 0xBB) -> rdata=0xAA; next read -> 0xBB. Write with wsel=5 when NWBUS=4 -> entry unchanged.
- rdone: read stream of 4 with rlast on the 4th -> rdone pulses once, aligned with the 4th rdata_val.
- Assert reset mid-stream between clock edges -> out_ren, rdata_val and rdone drop to 0 immediately; regfile data written before reset is still readable afterwards.
